// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-core RAM arbiter.
// RAM status codes, arbiter FSM states and the latched grant record.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_SERVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    typedef struct packed {
        logic        core;
        logic        is_data;
        arb_op_t     op;
        logic [31:0] addr;
        logic [31:0] store;
    } arb_grant_t;

    localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request/wait lines plus the RAM port.
// slave = arbiter view, master = caches + RAM model view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       iwait;
    logic [1:0]       dwait;
    logic [31:0]      load;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    ramstate_t        ramstate;
    logic             timeout;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, dwait, load,
        output ramREN, ramWEN, ramaddr, ramstore,
        output timeout
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, dwait, load,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  timeout
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port among two cores' icache/dcache.
// Round-robin across cores, dcache over icache within a core.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    arb_state_t r_state;
    arb_grant_t r_grant;
    logic       r_last_core;
    logic [7:0] r_cnt;
    logic       r_timeout;

    logic       w_any;
    logic       w_serve;
    logic       w_ack;
    logic [7:0] w_cnt_inc;
    arb_grant_t w_pick;
    logic [1:0] w_iack;
    logic [1:0] w_dack;

    // Core that did not win last time is tried first.
    function automatic arb_grant_t f_pick(
        input logic             last,
        input logic [1:0]       ir,
        input logic [1:0]       dr,
        input logic [1:0]       dw,
        input logic [1:0][31:0] ia,
        input logic [1:0][31:0] da,
        input logic [1:0][31:0] ds
    );
        arb_grant_t g;
        logic       c;
        g = '0;
        c = ~last;
        if (!(ir[c] | dr[c] | dw[c])) begin
            c = last;
        end
        g.core = c;
        if (dr[c] | dw[c]) begin
            g.is_data = 1'b1;
            g.op      = dw[c] ? OP_WRITE : OP_READ;
            g.addr    = da[c];
            g.store   = ds[c];
        end else begin
            g.is_data = 1'b0;
            g.op      = OP_READ;
            g.addr    = ia[c];
            g.store   = '0;
        end
        return g;
    endfunction

    assign w_any = |(bus.iREN | bus.dREN | bus.dWEN);

    assign w_pick = f_pick(r_last_core, bus.iREN, bus.dREN,
                           bus.dWEN, bus.iaddr, bus.daddr,
                           bus.dstore);

    assign w_serve = (r_state == ARB_SERVE);
    assign w_ack   = w_serve && (bus.ramstate == ACCESS);

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_last_core <= 1'b1;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= ARB_SERVE;
                    end
                end
                ARB_SERVE: begin
                    if (w_ack) begin
                        r_state     <= ARB_IDLE;
                        r_last_core <= r_grant.core;
                        r_cnt       <= '0;
                    end else begin
                        // Retry forever; the flag only reports it.
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TMO) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        w_iack = '0;
        w_dack = '0;
        if (w_ack) begin
            if (r_grant.is_data) begin
                w_dack[r_grant.core] = 1'b1;
            end else begin
                w_iack[r_grant.core] = 1'b1;
            end
        end
    end

    assign bus.iwait = bus.iREN & ~w_iack;
    assign bus.dwait = (bus.dREN | bus.dWEN) & ~w_dack;
    assign bus.load  = bus.ramload;

    assign bus.ramREN   = w_serve && (r_grant.op == OP_READ);
    assign bus.ramWEN   = w_serve && (r_grant.op == OP_WRITE);
    assign bus.ramaddr  = r_grant.addr;
    assign bus.ramstore = r_grant.store;
    assign bus.timeout  = r_timeout;

endmodule
